// File: rtl/g25_pushbutton_service_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : g25_pushbutton_service_ctrl
// Description : Avalon-MM master that services the pushbutton PIO slave.
//               It programs irq_mask (addr 2) after reset and on request.
//               On each interrupt it reads edge_capture (addr 3) and then
//               clears it. Non-zero captures are queued in a first-word
//               fall-through event FIFO with a valid/ready consumer port.
// Ports       : clk, reset (sync, active-high)
//               enable, mask_cfg, mask_load    - service / mask control
//               pio_address .. pio_writedata   - Avalon-MM master outputs
//               pio_readdata, pio_irq          - PIO slave responses
//               evt_data, evt_valid, evt_ready - event FIFO consumer port
//               evt_overflow, ovf_clear        - sticky drop flag and clear
//               busy                           - FSM is not idle in WAIT_IRQ
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module g25_pushbutton_service_ctrl #(
    parameter int               N_BTN      = 4,
    parameter int               FIFO_DEPTH = 4,
    parameter logic [N_BTN-1:0] MASK_INIT  = 4'hF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_BTN-1:0] mask_cfg,
    input  logic             mask_load,
    output logic [1:0]       pio_address,
    output logic             pio_chipselect,
    output logic             pio_write_n,
    output logic [31:0]      pio_writedata,
    input  logic [31:0]      pio_readdata,
    input  logic             pio_irq,
    output logic [N_BTN-1:0] evt_data,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_overflow,
    input  logic             ovf_clear,
    output logic             busy
);

    localparam int                 c_ptr_w        = $clog2(FIFO_DEPTH);
    localparam int                 c_cnt_w        = c_ptr_w + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one      = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_full     = c_cnt_w'(FIFO_DEPTH);
    localparam logic [1:0]         c_addr_mask    = 2'd2;
    localparam logic [1:0]         c_addr_capture = 2'd3;

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_WAIT_IRQ = 3'd1,
        S_RD_ADDR  = 3'd2,
        S_RD_DATA  = 3'd3,
        S_CLR      = 3'd4,
        S_PUSH     = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_BTN-1:0]   r_mask;
    logic               r_pend_mask;
    logic [N_BTN-1:0]   r_cap;

    logic [N_BTN-1:0]   r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_overflow;

    logic               w_full;
    logic               w_pop;
    logic               w_push_req;
    logic               w_push;
    logic               w_drop;
    logic               w_unused_rdata;

    // Only the low N_BTN bits of edge_capture carry button state.
    assign w_unused_rdata = ^pio_readdata[31:N_BTN];

    //--------------------------------------------------------------------------
    // Service FSM: next state and bus outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        pio_address    = 2'd0;
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_writedata  = 32'd0;
        case (r_state)
            S_INIT: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = c_addr_mask;
                pio_writedata  = {{(32-N_BTN){1'b0}}, r_mask};
                w_state_nxt    = S_WAIT_IRQ;
            end
            S_WAIT_IRQ: begin
                // A pending mask update goes out ahead of any waiting irq.
                if (r_pend_mask) begin
                    w_state_nxt = S_INIT;
                end else if (enable && pio_irq) begin
                    w_state_nxt = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                pio_chipselect = 1'b1;
                pio_address    = c_addr_capture;
                w_state_nxt    = S_RD_DATA;
            end
            S_RD_DATA: begin
                // Slave returns registered read data in this cycle.
                pio_address = c_addr_capture;
                w_state_nxt = S_CLR;
            end
            S_CLR: begin
                // Any write to edge_capture clears every bit.
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = c_addr_capture;
                w_state_nxt    = S_PUSH;
            end
            S_PUSH: begin
                // Guard cycle: the irq drops one cycle after the clear write,
                // so WAIT_IRQ never acts on the stale level.
                w_state_nxt = S_WAIT_IRQ;
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    assign busy = (r_state != S_WAIT_IRQ);

    //--------------------------------------------------------------------------
    // State register, mask bookkeeping and capture register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_INIT;
            r_mask      <= MASK_INIT;
            r_pend_mask <= 1'b0;
            r_cap       <= '0;
        end else begin
            r_state <= w_state_nxt;
            // A strobe landing in INIT itself keeps the request pending so
            // the newest value is still written.
            if (mask_load) begin
                r_mask      <= mask_cfg;
                r_pend_mask <= 1'b1;
            end else if (r_state == S_INIT) begin
                r_pend_mask <= 1'b0;
            end
            if (r_state == S_RD_DATA) begin
                r_cap <= pio_readdata[N_BTN-1:0];
            end
        end
    end

    //--------------------------------------------------------------------------
    // Event FIFO (first-word fall-through)
    //--------------------------------------------------------------------------
    assign evt_valid    = (r_count != '0);
    assign evt_data     = evt_valid ? r_mem[r_rd_ptr] : '0;
    assign evt_overflow = r_overflow;

    assign w_full     = (r_count == c_cnt_full);
    assign w_pop      = evt_valid && evt_ready;
    assign w_push_req = (r_state == S_PUSH) && (r_cap != '0);
    // When full, a same-cycle pop frees the slot being written.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_cap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as ovf_clear keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_g25_pushbutton_service_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_g25_pushbutton_service_ctrl
// Description : Self-checking bench for g25_pushbutton_service_ctrl. Contains a
//               behavioural pushbutton PIO slave (irq_mask, edge_capture,
//               registered read data) and a queue of expected FIFO events.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_g25_pushbutton_service_ctrl;

    localparam int c_depth = 4;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        enable    = 1'b1;
    logic        mask_load = 1'b0;
    logic        evt_ready = 1'b0;
    logic        ovf_clear = 1'b0;
    logic [3:0]  mask_cfg  = 4'h0;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata = 32'd0;
    logic        pio_irq;
    logic [3:0]  evt_data;
    logic        evt_valid;
    logic        evt_overflow;
    logic        busy;

    // PIO slave model state; edge_capture is not affected by the DUT reset.
    logic [3:0]  press    = 4'h0;
    logic [3:0]  pio_cap  = 4'h0;
    logic [3:0]  pio_mask = 4'h0;

    int          n_checks    = 0;
    int          n_errors    = 0;
    int          mask_wr_cnt = 0;
    int          rd3_cnt     = 0;
    int          wr3_cnt     = 0;
    logic [31:0] last_mask_wd = 32'd0;
    logic [3:0]  exp_q [$];
    logic        exp_ovf;

    always #5 clk = ~clk;

    g25_pushbutton_service_ctrl #(
        .N_BTN      (4),
        .FIFO_DEPTH (c_depth),
        .MASK_INIT  (4'hF)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .mask_cfg       (mask_cfg),
        .mask_load      (mask_load),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .pio_irq        (pio_irq),
        .evt_data       (evt_data),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_overflow   (evt_overflow),
        .ovf_clear      (ovf_clear),
        .busy           (busy)
    );

    assign pio_irq = |(pio_cap & pio_mask);

    always @(posedge clk) begin
        if (pio_chipselect && pio_write_n && pio_address == 2'd3)
            pio_readdata <= {28'd0, pio_cap};
        else if (pio_chipselect && pio_write_n && pio_address == 2'd2)
            pio_readdata <= {28'd0, pio_mask};
        if (pio_chipselect && !pio_write_n && pio_address == 2'd3)
            pio_cap <= press;
        else
            pio_cap <= pio_cap | press;
        if (pio_chipselect && !pio_write_n && pio_address == 2'd2)
            pio_mask <= pio_writedata[3:0];
    end

    // Bus transaction counters.
    always @(posedge clk) begin
        if (!reset && pio_chipselect) begin
            if (!pio_write_n && pio_address == 2'd2) begin
                mask_wr_cnt  = mask_wr_cnt + 1;
                last_mask_wd = pio_writedata;
            end
            if (pio_write_n && pio_address == 2'd3)
                rd3_cnt = rd3_cnt + 1;
            if (!pio_write_n && pio_address == 2'd3)
                wr3_cnt = wr3_cnt + 1;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns just after the edge on which edge_capture latches the press.
    task automatic press_btn(input logic [3:0] b);
        @(negedge clk);
        press = b;
        @(posedge clk);
        #1;
        press = 4'h0;
    endtask

    // Pop one event and compare it with the head of the expected queue.
    task automatic sb_pop(input string tag);
        logic [3:0] e;
        int         t;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'h0;
        t = 0;
        while (!evt_valid && t < 20) begin
            tick(1);
            t = t + 1;
        end
        check_value({tag, "_valid"}, 32'(evt_valid), 32'd1);
        check_value(tag, 32'(evt_data), 32'(e));
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r0;
        int w0;
        int mw0;
        logic [3:0] t3_seq [5];
        logic [3:0] t4_seq [4];
        t3_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        t4_seq = '{4'h8, 4'h4, 4'h2, 4'h1};
        exp_ovf = 1'b0;

        // T1: reset release, INIT mask write then idle bus.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_value("t1_cs",     32'(pio_chipselect), 32'd1);
        check_value("t1_wr_n",   32'(pio_write_n),    32'd0);
        check_value("t1_addr",   32'(pio_address),    32'd2);
        check_value("t1_wdata",  pio_writedata,       32'hF);
        check_value("t1_busy",   32'(busy),           32'd1);
        check_value("t1_valid",  32'(evt_valid),      32'd0);
        check_value("t1_data",   32'(evt_data),       32'd0);
        check_value("t1_ovf",    32'(evt_overflow),   32'd0);
        tick(1);
        check_value("t1_idle_busy",  32'(busy),           32'd0);
        check_value("t1_idle_cs",    32'(pio_chipselect), 32'd0);
        check_value("t1_idle_wr_n",  32'(pio_write_n),    32'd1);
        check_value("t1_idle_addr",  32'(pio_address),    32'd0);
        check_value("t1_idle_wdata", pio_writedata,       32'd0);

        // T2: single press, five-cycle latency, one read and one clear.
        r0 = rd3_cnt;
        w0 = wr3_cnt;
        press_btn(4'b0010);
        exp_q.push_back(4'b0010);
        tick(4);
        check_value("t2_lat4_valid", 32'(evt_valid), 32'd0);
        tick(1);
        check_value("t2_lat5_valid", 32'(evt_valid), 32'd1);
        check_value("t2_rd3", 32'(rd3_cnt - r0), 32'd1);
        check_value("t2_wr3", 32'(wr3_cnt - w0), 32'd1);
        sb_pop("t2_pop");
        check_value("t2_empty", 32'(evt_valid), 32'd0);

        // T3: five presses with no consumer; the fifth is dropped.
        for (int i = 0; i < 5; i++) begin
            press_btn(t3_seq[i]);
            if (exp_q.size() < c_depth) exp_q.push_back(t3_seq[i]);
            else exp_ovf = 1'b1;
            tick(6);
            check_value("t3_ovf", 32'(evt_overflow), 32'(exp_ovf));
        end
        ovf_clear = 1'b1;
        tick(1);
        ovf_clear = 1'b0;
        check_value("t3_ovf_clr", 32'(evt_overflow), 32'd0);
        for (int i = 0; i < 4; i++) sb_pop("t3_pop");
        check_value("t3_empty_valid", 32'(evt_valid), 32'd0);
        check_value("t3_empty_data",  32'(evt_data),  32'd0);

        // T4: full FIFO, pop coincides with PUSH -> both proceed.
        for (int i = 0; i < 4; i++) begin
            press_btn(t4_seq[i]);
            exp_q.push_back(t4_seq[i]);
            tick(6);
        end
        press_btn(4'h6);
        tick(4);
        evt_ready = 1'b1;
        check_value("t4_head", 32'(evt_data), 32'(exp_q.pop_front()));
        tick(1);
        evt_ready = 1'b0;
        exp_q.push_back(4'h6);
        check_value("t4_ovf",   32'(evt_overflow), 32'd0);
        check_value("t4_valid", 32'(evt_valid),    32'd1);
        for (int i = 0; i < 4; i++) sb_pop("t4_pop");
        check_value("t4_empty", 32'(evt_valid), 32'd0);

        // Disabled: irq stays pending with no service until enabled.
        enable = 1'b0;
        press_btn(4'h8);
        tick(10);
        check_value("en0_busy",  32'(busy),      32'd0);
        check_value("en0_valid", 32'(evt_valid), 32'd0);
        enable = 1'b1;
        exp_q.push_back(4'h8);
        sb_pop("en1_pop");

        // T5: mask_load during RD_ADDR; service finishes, then one mask write.
        mw0 = mask_wr_cnt;
        press_btn(4'h2);
        tick(1);
        mask_cfg  = 4'h5;
        mask_load = 1'b1;
        tick(1);
        mask_load = 1'b0;
        exp_q.push_back(4'h2);
        tick(8);
        check_value("t5_mask_wr_cnt", 32'(mask_wr_cnt - mw0), 32'd1);
        check_value("t5_mask_wdata",  last_mask_wd,           32'h5);
        sb_pop("t5_pop");
        press_btn(4'h4);
        exp_q.push_back(4'h4);
        sb_pop("t5_pop_after");

        // T6: two events queued, reset lands as the FSM would enter CLR.
        press_btn(4'h1);
        exp_q.push_back(4'h1);
        tick(6);
        press_btn(4'h4);
        exp_q.push_back(4'h4);
        tick(6);
        check_value("t6_queued", 32'(evt_valid), 32'd1);
        press_btn(4'h1);
        tick(2);
        reset = 1'b1;
        tick(1);
        check_value("t6_valid", 32'(evt_valid),      32'd0);
        check_value("t6_data",  32'(evt_data),       32'd0);
        check_value("t6_busy",  32'(busy),           32'd1);
        check_value("t6_cs",    32'(pio_chipselect), 32'd1);
        check_value("t6_wr_n",  32'(pio_write_n),    32'd0);
        check_value("t6_addr",  32'(pio_address),    32'd2);
        check_value("t6_wdata", pio_writedata,       32'hF);
        reset = 1'b0;
        exp_q.delete();
        exp_q.push_back(4'h1);
        sb_pop("t6_pop");
        check_value("t6_empty", 32'(evt_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
